// File: rtl/dense_layer_sequencer_pkg.sv
// Purpose: shared types and default dimensions for the dense-layer sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state_t (sequencer FSM states), DEF_IN_DIM / DEF_OUT_DIM / DEF_ACC_WIDTH.
package dense_ctrl_pkg;

    localparam int DEF_IN_DIM    = 128;
    localparam int DEF_OUT_DIM   = 10;
    localparam int DEF_ACC_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_PREV = 3'd2,
        LOAD      = 3'd3,
        MAC       = 3'd4,
        WRITE     = 3'd5,
        DONE      = 3'd6
    } state_t;

endpackage

// File: rtl/dense_mac_unit.sv
// Purpose: signed 8x8 multiply-accumulate with bias preload on the first term.
// Latency: one cycle from (en, operands) to the updated acc register.
// Backpressure: none; the accumulator only advances while en is high.
// Ports: clk, resetn (sync, active-low), en, first (replace acc with bias),
//        w_data / act / b_data (signed 8-bit operands), acc (ACC_WIDTH result).
module dense_mac_unit #(
    parameter int ACC_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 en,
    input  logic                 first,
    input  logic signed [7:0]    w_data,
    input  logic signed [7:0]    act,
    input  logic signed [7:0]    b_data,
    output logic [ACC_WIDTH-1:0] acc
);

    logic signed [15:0]   prod;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] base;
    logic [ACC_WIDTH-1:0] acc_d;
    logic [ACC_WIDTH-1:0] acc_q;

    always_comb begin
        prod     = w_data * act;
        prod_ext = {{(ACC_WIDTH-16){prod[15]}}, prod};
        // First term of a neuron starts from the bias instead of the old sum.
        base     = first ? {{(ACC_WIDTH-8){b_data[7]}}, b_data} : acc_q;
        acc_d    = acc_q;
        if (en) begin
            acc_d = base + prod_ext;   // wraps modulo 2^ACC_WIDTH
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/dense_layer_sequencer.sv
// Purpose: sequences one time-multiplexed dense layer (trigger upstream, load vector, MAC each neuron, write out).
// Latency: prev_done at T -> neuron j written at T+IN_DIM+(j+1)*(IN_DIM+2); done at T+IN_DIM+OUT_DIM*(IN_DIM+2)+1.
// Backpressure: none; start is ignored while busy, downstream must accept every out_we strobe.
// Ports: clk, resetn (sync, active-low), start/busy/done handshake, prev_* upstream trigger and
//        combinational read, w_*/b_* synchronous ROM ports (1-cycle latency), out_* write port.
// Optional: define DENSE_ARGMAX_EN to add class_idx (running argmax of written results).
module dense_layer_sequencer
    import dense_ctrl_pkg::*;
#(
    parameter int IN_DIM    = DEF_IN_DIM,
    parameter int OUT_DIM   = DEF_OUT_DIM,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    output logic                               prev_start,
    input  logic                               prev_done,
    output logic [$clog2(IN_DIM)-1:0]          prev_addr,
    input  logic [7:0]                         prev_data,
    output logic [$clog2(IN_DIM*OUT_DIM)-1:0]  w_addr,
    input  logic [7:0]                         w_data,
    output logic [$clog2(OUT_DIM)-1:0]         b_addr,
    input  logic [7:0]                         b_data,
    output logic                               out_we,
    output logic [$clog2(OUT_DIM)-1:0]         out_addr,
    output logic [ACC_WIDTH-1:0]               out_data
`ifdef DENSE_ARGMAX_EN
    ,
    output logic [$clog2(OUT_DIM)-1:0]         class_idx
`endif
);

    localparam int IW = $clog2(IN_DIM);
    localparam int OW = $clog2(OUT_DIM);
    localparam int WW = $clog2(IN_DIM*OUT_DIM);
    // Phase counter must reach IN_DIM (the drain cycle of a neuron).
    localparam int CW = $clog2(IN_DIM+1);

    state_t          state_d, state_q;
    logic [CW-1:0]   cnt_d, cnt_q;
    logic [OW-1:0]   neuron_d, neuron_q;

    logic signed [7:0] act_buf_q [IN_DIM];
    logic              buf_we;
    logic [IW-1:0]     buf_waddr;
    logic [IW-1:0]     rd_idx;

    logic                 mac_en;
    logic                 mac_first;
    logic signed [7:0]    mac_act;
    logic [ACC_WIDTH-1:0] acc;

    // ---------------------------------------------------------------
    // FSM next state and counters
    // ---------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        neuron_d = neuron_q;
        case (state_q)
            IDLE, DONE: begin
                // start wins over any stray prev_done here
                if (start) begin
                    state_d = TRIG;
                end
            end
            TRIG: begin
                state_d = WAIT_PREV;
            end
            WAIT_PREV: begin
                if (prev_done) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (cnt_q == CW'(IN_DIM-1)) begin
                    state_d  = MAC;
                    cnt_d    = '0;
                    neuron_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            MAC: begin
                // cycles 0..IN_DIM-1 issue ROM reads, cycle IN_DIM drains the last product
                if (cnt_q == CW'(IN_DIM)) begin
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WRITE: begin
                cnt_d = '0;
                if (neuron_q == OW'(OUT_DIM-1)) begin
                    state_d = DONE;
                end else begin
                    state_d  = MAC;
                    neuron_d = neuron_q + OW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            neuron_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            neuron_q <= neuron_d;
        end
    end

    // ---------------------------------------------------------------
    // Activation buffer (contents are don't-care after reset)
    // ---------------------------------------------------------------
    always_comb begin
        buf_we    = (state_q == LOAD);
        buf_waddr = cnt_q[IW-1:0];
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            act_buf_q[buf_waddr] <= prev_data;
        end
    end

    // ---------------------------------------------------------------
    // MAC: the weight issued in cycle c returns in c+1, so the product in
    // cycle c+1 pairs it with buf[c]; the bias addressed in cycle 0 seeds cycle 1.
    // ---------------------------------------------------------------
    always_comb begin
        rd_idx    = cnt_q[IW-1:0] - IW'(1);
        mac_en    = (state_q == MAC) && (cnt_q != '0);
        mac_first = (state_q == MAC) && (cnt_q == CW'(1));
        mac_act   = act_buf_q[rd_idx];
    end

    dense_mac_unit #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk    (clk),
        .resetn (resetn),
        .en     (mac_en),
        .first  (mac_first),
        .w_data (w_data),
        .act    (mac_act),
        .b_data (b_data),
        .acc    (acc)
    );

    // ---------------------------------------------------------------
    // Outputs; addresses are parked at zero outside their active phase
    // ---------------------------------------------------------------
    always_comb begin
        busy       = (state_q != IDLE) && (state_q != DONE);
        done       = (state_q == DONE);
        prev_start = (state_q == TRIG);
        prev_addr  = '0;
        w_addr     = '0;
        b_addr     = '0;
        out_we     = 1'b0;
        out_addr   = '0;
        out_data   = '0;
        if (state_q == LOAD) begin
            prev_addr = cnt_q[IW-1:0];
        end
        if ((state_q == MAC) && (cnt_q < CW'(IN_DIM))) begin
            w_addr = WW'(neuron_q) * WW'(IN_DIM) + WW'(cnt_q);
            if (cnt_q == '0) begin
                b_addr = neuron_q;
            end
        end
        if (state_q == WRITE) begin
            out_we   = 1'b1;
            out_addr = neuron_q;
            out_data = acc;
        end
    end

`ifdef DENSE_ARGMAX_EN
    // ---------------------------------------------------------------
    // Running argmax; strict > keeps the lowest index on ties.
    // ---------------------------------------------------------------
    logic                 start_acc;
    logic [ACC_WIDTH-1:0] max_d, max_q;
    logic [OW-1:0]        class_d, class_q;

    always_comb begin
        start_acc = start && ((state_q == IDLE) || (state_q == DONE));
        max_d     = max_q;
        class_d   = class_q;
        if (start_acc) begin
            max_d   = '0;
            class_d = '0;
        end else if (state_q == WRITE) begin
            if ((neuron_q == '0) || ($signed(acc) > $signed(max_q))) begin
                max_d   = acc;
                class_d = neuron_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            max_q   <= '0;
            class_q <= '0;
        end else begin
            max_q   <= max_d;
            class_q <= class_d;
        end
    end

    assign class_idx = class_q;
`endif

endmodule

// File: doc/dense_layer_sequencer.md
# dense_layer_sequencer

Control and datapath sequencer for one time-multiplexed fully connected layer. It triggers the upstream layer, copies that layer's activation vector into a local buffer, and computes each output neuron on a single shared MAC. The MAC is fed from external synchronous weight and bias ROMs. Results stream out through a write port to the downstream output buffer. It is the standard driver for the CIFAR-10 head (128 to 10) and for any later dense stage.

## Interface
- IN_DIM, 128, input vector length
- OUT_DIM, 10, number of output neurons
- ACC_WIDTH, 32, accumulator and output width
- clk  in  1  clock; all logic on the rising edge
- resetn  in  1  synchronous, active-low reset
- start  in  1  single-cycle request; sampled only in IDLE or DONE
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  level; high in DONE until the next accepted start or reset
- prev_start  out  1  one-cycle pulse that triggers the upstream layer
- prev_done  in  1  upstream finished; sampled only in WAIT_PREV
- prev_addr  out  $clog2(IN_DIM)  upstream read address; combinational read
- prev_data  in  8  signed upstream activation, valid in the same cycle as prev_addr
- w_addr  out  $clog2(IN_DIM*OUT_DIM)  weight ROM address; 1-cycle read latency
- w_data  in  8  signed weight
- b_addr  out  $clog2(OUT_DIM)  bias ROM address; 1-cycle read latency
- b_data  in  8  signed bias
- out_we  out  1  one-cycle write strobe
- out_addr  out  $clog2(OUT_DIM)  output neuron index
- out_data  out  ACC_WIDTH  signed neuron result
- class_idx  out  $clog2(OUT_DIM)  argmax result; present only with DENSE_ARGMAX_EN

## Operation
- States and transitions:
  - IDLE: on start, go to TRIG.
  - TRIG: prev_start=1 for this one cycle, then go to WAIT_PREV.
  - WAIT_PREV: on prev_done, go to LOAD.
  - LOAD: lasts IN_DIM cycles.
  - MAC: lasts IN_DIM+1 cycles per neuron.
  - WRITE: lasts 1 cycle. Go back to MAC for the next neuron, or to DONE after neuron OUT_DIM-1.
  - DONE: on start, go to TRIG.
- LOAD: in cycle k, drive prev_addr=k and store prev_data into buf[k].
- MAC for neuron j:
  - In issue cycle i (0..IN_DIM-1), drive w_addr=j*IN_DIM+i.
  - In issue cycle 0, also drive b_addr=j.
  - The product uses the weight returned one cycle later together with buf[i].
  - Accumulate: acc <= (first ? sext(b_data) : acc) + sext(w*buf).
- Arithmetic: the 8x8 signed product is 16 bits, sign-extended to ACC_WIDTH. The sum wraps modulo 2^ACC_WIDTH; there is no saturation.
- WRITE: out_we=1, out_addr=j, out_data=acc.
- Boundary rules:
  - start while busy is ignored.
  - start in DONE drops done on the next cycle and relaunches the whole sequence.
  - prev_done outside WAIT_PREV is ignored.
  - prev_done and start asserted together in IDLE: only start acts.
  - resetn low in any state returns to IDLE next cycle and aborts all writes; buf contents are don't-care.

## Timing
- Reset values of outputs:
  - busy, done, prev_start, out_we: 0.
  - All address outputs, out_data and class_idx: 0.
- start accepted in cycle S: prev_start is high in S+1 and busy is high from S+1.
- prev_done sampled in cycle T:
  - LOAD occupies T+1..T+IN_DIM.
  - Neuron j's first issue cycle is T+IN_DIM+1+j*(IN_DIM+2).
  - Neuron j's out_we cycle is T+IN_DIM+(j+1)*(IN_DIM+2).
  - done rises at T+IN_DIM+OUT_DIM*(IN_DIM+2)+1, which is T+1429 for the defaults; busy falls in the same cycle.
- out_we is never asserted on two consecutive cycles.

## Configuration
- DENSE_ARGMAX_EN defined:
  - class_idx tracks the running maximum of out_data on each write, using strict greater-than, so the lowest index wins ties.
  - It holds the final value while done is high and clears on an accepted start.
- DENSE_ARGMAX_EN undefined: the port and the compare logic are absent; all other behaviour is identical.

## Structure
- Package dense_ctrl_pkg holds:
  - state_t enum (IDLE, TRIG, WAIT_PREV, LOAD, MAC, WRITE, DONE);
  - default IN_DIM, OUT_DIM and ACC_WIDTH localparams.
- Sub-module dense_mac_unit: signed 8x8 multiply, first-cycle bias load, ACC_WIDTH accumulate register.
- The FSM, counters and buffer stay in the top module.

## Test plan
- Case 1, all weights=1, biases=0, activations=1: each out_data=128, out_addr 0..9, done at T+1429.
- Case 2, bias[3]=-5, activations=0: out_data[3]=-5 and all others 0.
- Case 3, weights=-128, activations=-128, bias=127: out_data=128*16384+127=2097279, which checks sign extension.
- Case 4, start pulsed during MAC, then resetn low for 1 cycle mid-neuron 4: the start is ignored; after reset, busy=0, done=0, no further out_we, and a new start completes normally.
- Case 5, DENSE_ARGMAX_EN with outputs {5,9,9,2,...}: class_idx=1 (tie resolved to the lower index), cleared on the next start.
